exec_alu_mc: RTL and testbench



---
 rtl/exec_alu_mc_if.sv | 42 ++++
 rtl/exec_alu_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_exec_alu_mc.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_mc_if.sv
// exec_alu_mc_if
//   Operation/result bundle between register-read, the execute unit and
//   memory/writeback.
//   master : the producer/consumer side (drives operations, takes results)
//   slave  : the execute unit
//   Signals: flushIn, inValid/inReady, aluOpIn, operand1In, operand2In,
//            immIn, useImmIn, outValid/outReady, resultOut, resultHiOut,
//            resultHiValidOut, resultWriteOut, flagsOut {CF,ZF,SF,OF},
//            killOut, busyOut.
interface exec_alu_mc_if #(
  parameter int WIDTH = 64
);
  logic             flushIn;
  logic             inValid;
  logic             inReady;
  logic [3:0]       aluOpIn;
  logic [WIDTH-1:0] operand1In;
  logic [WIDTH-1:0] operand2In;
  logic [WIDTH-1:0] immIn;
  logic             useImmIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] resultOut;
  logic [WIDTH-1:0] resultHiOut;
  logic             resultHiValidOut;
  logic             resultWriteOut;
  logic [3:0]       flagsOut;
  logic             killOut;
  logic             busyOut;

  modport master (
    output flushIn, inValid, aluOpIn, operand1In, operand2In, immIn, useImmIn, outReady,
    input  inReady, outValid, resultOut, resultHiOut, resultHiValidOut, resultWriteOut,
           flagsOut, killOut, busyOut
  );

  modport slave (
    input  flushIn, inValid, aluOpIn, operand1In, operand2In, immIn, useImmIn, outReady,
    output inReady, outValid, resultOut, resultHiOut, resultHiValidOut, resultWriteOut,
           flagsOut, killOut, busyOut
  );
endinterface

// File: rtl/exec_alu_mc.sv
// exec_alu_mc
//   Multi-cycle integer execute unit. Single-cycle ALU ops load the output
//   register on the accepting edge; MUL/IMUL run an iterative shift-add
//   multiplier retiring MUL_STEP bits per cycle and produce a double-width
//   product. An architectural flags register {CF,ZF,SF,OF} is updated
//   whenever the output register is loaded.
//   Ports: clk, reset (synchronous, active-high), bus (exec_alu_mc_if.slave).
//   Parameters: WIDTH (even, >= 8), MUL_STEP (divides WIDTH).
module exec_alu_mc #(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input logic          clk,
  input logic          reset,
  exec_alu_mc_if.slave bus
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_MOV  = 4'd0,  OP_ADD = 4'd1,  OP_ADC = 4'd2,  OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBB  = 4'd4,  OP_CMP = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8,  OP_NOT = 4'd9,  OP_NEG = 4'd10, OP_INC = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12, OP_MUL = 4'd13, OP_IMUL = 4'd14, OP_KILL = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic               r_signed;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_hi_valid;
  logic               r_write;
  logic               r_kill;
  logic [3:0]         r_flags;

  logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_min, w_max;
  logic               w_in_ready, w_accept, w_out_free, w_is_mul, w_is_imul;
  logic [WIDTH:0]     w_add, w_sub;
  logic               w_add_of, w_sub_of;
  logic [WIDTH-1:0]   w_res;
  logic               w_cf, w_of, w_set_flags, w_write, w_kill;
  logic [3:0]         w_flags;
  logic [2*WIDTH-1:0] w_pp [MUL_STEP];
  logic [2*WIDTH-1:0] w_pp_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_prod_hi, w_prod_lo;
  logic               w_mul_ovf;

  assign w_a   = bus.operand1In;
  assign w_b   = bus.useImmIn ? bus.immIn : bus.operand2In;
  assign w_min = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_max = ~w_min;

  assign w_out_free = !r_out_valid || bus.outReady;
  assign w_in_ready = (r_state == S_IDLE) && w_out_free && !bus.flushIn;
  assign w_accept   = bus.inValid && w_in_ready;
  assign w_is_mul   = (bus.aluOpIn == OP_MUL) || (bus.aluOpIn == OP_IMUL);
  assign w_is_imul  = (bus.aluOpIn == OP_IMUL);

  // Carry-in is the architectural CF only for the with-carry variants.
  assign w_add    = {1'b0, w_a} + {1'b0, w_b}
                  + (WIDTH+1)'((bus.aluOpIn == OP_ADC) && r_flags[3]);
  assign w_sub    = {1'b0, w_a} - {1'b0, w_b}
                  - (WIDTH+1)'((bus.aluOpIn == OP_SBB) && r_flags[3]);
  assign w_add_of = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
  assign w_sub_of = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);

  always_comb begin
    w_res       = '0;
    w_write     = 1'b1;
    w_kill      = 1'b0;
    w_cf        = r_flags[3];
    w_of        = r_flags[0];
    w_set_flags = 1'b1;
    case (bus.aluOpIn)
      OP_MOV: begin
        w_res       = w_b;
        w_set_flags = 1'b0;
      end
      OP_ADD, OP_ADC: begin
        w_res = w_add[MSB:0];
        w_cf  = w_add[WIDTH];
        w_of  = w_add_of;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        w_res   = w_sub[MSB:0];
        w_cf    = w_sub[WIDTH];
        w_of    = w_sub_of;
        w_write = (bus.aluOpIn != OP_CMP);
      end
      OP_AND, OP_OR, OP_XOR: begin
        w_res = (bus.aluOpIn == OP_AND) ? (w_a & w_b) :
                (bus.aluOpIn == OP_OR)  ? (w_a | w_b) : (w_a ^ w_b);
        w_cf  = 1'b0;
        w_of  = 1'b0;
      end
      OP_NOT: begin
        w_res       = ~w_a;
        w_set_flags = 1'b0;
      end
      OP_NEG: begin
        w_res = '0 - w_a;
        w_cf  = |w_a;
        w_of  = (w_a == w_min);
      end
      OP_INC: begin
        w_res = w_a + WIDTH'(1);
        w_of  = (w_a == w_max);
      end
      OP_DEC: begin
        w_res = w_a - WIDTH'(1);
        w_of  = (w_a == w_min);
      end
      OP_KILL: begin
        w_write     = 1'b0;
        w_kill      = 1'b1;
        w_set_flags = 1'b0;
      end
      default: w_set_flags = 1'b0;
    endcase
    w_flags = w_set_flags ? {w_cf, (w_res == '0), w_res[MSB], w_of} : r_flags;
  end

  // IMUL works on magnitudes; the sign is reapplied to the full product.
  assign w_a_mag = (w_is_imul && w_a[MSB]) ? ('0 - w_a) : w_a;
  assign w_b_mag = (w_is_imul && w_b[MSB]) ? ('0 - w_b) : w_b;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
      assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_pp_sum = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      w_pp_sum = w_pp_sum + w_pp[j];
    end
  end

  assign w_prod    = r_neg ? ('0 - r_acc) : r_acc;
  assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH];
  assign w_prod_lo = w_prod[MSB:0];
  assign w_mul_ovf = r_signed ? (w_prod_hi != {WIDTH{w_prod_lo[MSB]}}) : (|w_prod_hi);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_neg       <= 1'b0;
      r_signed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_hi_valid  <= 1'b0;
      r_write     <= 1'b0;
      r_kill      <= 1'b0;
      r_flags     <= '0;
    end else if (bus.flushIn) begin
      // Abort: the in-flight product and pending beat are dropped, flags kept.
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // Drain; a load below on the same edge takes precedence.
      if (r_out_valid && bus.outReady) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
              r_mplier <= w_b_mag;
              r_acc    <= '0;
              r_neg    <= w_is_imul && (w_a[MSB] ^ w_b[MSB]);
              r_signed <= w_is_imul;
              r_cnt    <= CNT_W'(STEPS);
              r_state  <= S_MUL;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_result_hi <= '0;
              r_hi_valid  <= 1'b0;
              r_write     <= w_write;
              r_kill      <= w_kill;
              r_flags     <= w_flags;
            end
          end
        end
        S_MUL, S_HOLD: begin
          if (r_state == S_MUL && r_cnt != '0) begin
            r_acc    <= r_acc + w_pp_sum;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_cnt    <= r_cnt - CNT_W'(1);
          end else if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_result    <= w_prod_lo;
            r_result_hi <= w_prod_hi;
            r_hi_valid  <= 1'b1;
            r_write     <= 1'b1;
            r_kill      <= 1'b0;
            r_flags     <= {w_mul_ovf, (w_prod_lo == '0), w_prod_lo[MSB], w_mul_ovf};
            r_state     <= S_IDLE;
          end else begin
            // Product parked in r_acc/r_neg until the output register frees.
            r_state <= S_HOLD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inReady          = w_in_ready;
  assign bus.outValid         = r_out_valid;
  assign bus.resultOut        = r_result;
  assign bus.resultHiOut      = r_result_hi;
  assign bus.resultHiValidOut = r_hi_valid;
  assign bus.resultWriteOut   = r_write;
  assign bus.flagsOut         = r_flags;
  assign bus.killOut          = r_kill;
  assign bus.busyOut          = (r_state != S_IDLE);

endmodule

// File: tb/tb_exec_alu_mc.sv
// tb_exec_alu_mc
//   Randomized scoreboard bench for exec_alu_mc (WIDTH=64, MUL_STEP=1) plus
//   a small directed/random multiplier check on a WIDTH=8, MUL_STEP=2 copy.
module tb_exec_alu_mc;
  localparam int W = 64;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         hiv;
    logic         wr;
    logic         kill;
    logic [3:0]   fl;
    logic         care_res;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_alu_mc_if #(.WIDTH(W)) bus ();
  exec_alu_mc #(.WIDTH(W), .MUL_STEP(1)) dut (.clk(clk), .reset(reset), .bus(bus));

  exec_alu_mc_if #(.WIDTH(8)) bus8 ();
  exec_alu_mc #(.WIDTH(8), .MUL_STEP(2)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       q[$];
  logic [3:0] m_flags = 4'h0;
  bit         rnd_ready = 0;
  bit         force_ready = 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [W+1:0] sx(input logic [W-1:0] v);
    return (W+2)'($signed(v));
  endfunction

  function automatic logic [3:0] mkfl(input logic c, input logic [W-1:0] r, input logic ov);
    return {c, (r == '0), r[W-1], ov};
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [3:0] fin);
    exp_t e;
    logic ci;
    logic [W+1:0] uexact;
    logic signed [W+1:0] exact;
    logic [2*W-1:0] up;
    logic signed [2*W-1:0] sp;
    e = '0; e.op = op; e.wr = 1'b1; e.fl = fin; e.care_res = 1'b1;
    case (op)
      4'd0: e.res = b;
      4'd1, 4'd2: begin
        ci = (op == 4'd2) ? fin[3] : 1'b0;
        uexact = {2'b00, a} + {2'b00, b} + (W+2)'(ci);
        e.res = uexact[W-1:0];
        exact = sx(a) + sx(b) + (W+2)'(ci);
        e.fl = mkfl((uexact >> W) != 0, e.res, exact != sx(e.res));
      end
      4'd3, 4'd4, 4'd5: begin
        ci = (op == 4'd4) ? fin[3] : 1'b0;
        e.res = a - b - W'(ci);
        exact = sx(a) - sx(b) - (W+2)'(ci);
        e.fl = mkfl({1'b0, a} < ({1'b0, b} + (W+1)'(ci)), e.res, exact != sx(e.res));
        if (op == 4'd5) begin e.wr = 1'b0; e.care_res = 1'b0; end
      end
      4'd6, 4'd7, 4'd8: begin
        e.res = (op == 4'd6) ? (a & b) : (op == 4'd7) ? (a | b) : (a ^ b);
        e.fl = mkfl(1'b0, e.res, 1'b0);
      end
      4'd9: e.res = ~a;
      4'd10: begin
        e.res = -a;
        exact = -sx(a);
        e.fl = mkfl(a != 0, e.res, exact != sx(e.res));
      end
      4'd11, 4'd12: begin
        e.res = (op == 4'd11) ? a + 1 : a - 1;
        exact = (op == 4'd11) ? sx(a) + 1 : sx(a) - 1;
        e.fl = mkfl(fin[3], e.res, exact != sx(e.res));
      end
      4'd13: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = up[W-1:0]; e.hi = up[2*W-1:W]; e.hiv = 1'b1;
        e.fl = mkfl(e.hi != 0, e.res, e.hi != 0);
      end
      4'd14: begin
        sp = (2*W)'($signed(a)) * (2*W)'($signed(b));
        e.res = sp[W-1:0]; e.hi = sp[2*W-1:W]; e.hiv = 1'b1;
        e.fl = mkfl(sp != (2*W)'($signed(e.res)), e.res, sp != (2*W)'($signed(e.res)));
      end
      default: begin
        e.wr = 1'b0; e.kill = 1'b1; e.care_res = 1'b0;
      end
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  exp_t           mon_e;
  logic [W-1:0]   mon_res;
  always @(negedge clk) begin
    if (!reset && bus.outValid) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL beat_unexpected: got beat result %0h, expected no beat", bus.resultOut);
      end else begin
        mon_e = q[0];
        mon_res = mon_e.care_res ? bus.resultOut : mon_e.res;
        check($sformatf("beat op=%0d", mon_e.op),
              {mon_res, bus.resultHiOut, bus.resultHiValidOut, bus.resultWriteOut, bus.killOut, bus.flagsOut},
              {mon_e.res, mon_e.hi, mon_e.hiv, mon_e.wr, mon_e.kill, mon_e.fl});
        if (bus.outReady) void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.outReady = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.outReady = rnd_ready ? ($urandom_range(3) != 0) : force_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input bit use_imm, output int waited);
    bit acc;
    exp_t e;
    bus.aluOpIn = op; bus.operand1In = a; bus.operand2In = b;
    bus.immIn = imm; bus.useImmIn = use_imm; bus.inValid = 1'b1;
    waited = 0; acc = 0;
    while (!acc && waited <= 300) begin
      @(negedge clk);
      if (bus.inReady) acc = 1; else waited++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout op=%0d: got no accept in %0d cycles, expected accept", op, waited);
    end else begin
      e = model(op, a, use_imm ? imm : b, m_flags);
      q.push_back(e);
      m_flags = e.fl;
    end
    @(posedge clk); #1;
    bus.inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || bus.outValid) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
    end
  endtask

  function automatic logic [W-1:0] rval();
    case ($urandom_range(7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return W'($urandom_range(9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    bus8.aluOpIn = op; bus8.operand1In = a; bus8.operand2In = b; bus8.useImmIn = 1'b0;
    bus8.inValid = 1'b1;
    @(negedge clk);
    check("mul8_in_ready", bus8.inReady, 1'b1);
    @(posedge clk); #1;
    bus8.inValid = 1'b0;
    lat = 0;
    while (!bus8.outValid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int w, w2, lat;
    bit busy_ok;
    logic [3:0] saved;
    logic [7:0] a8, b8;
    logic [15:0] up8;
    logic signed [15:0] sp8;
    logic ov8;
    logic [3:0] op8;

    bus.flushIn = 0; bus.inValid = 0; bus.aluOpIn = 0; bus.operand1In = 0;
    bus.operand2In = 0; bus.immIn = 0; bus.useImmIn = 0;
    bus8.flushIn = 0; bus8.inValid = 0; bus8.aluOpIn = 0; bus8.operand1In = 0;
    bus8.operand2In = 0; bus8.immIn = 0; bus8.useImmIn = 0; bus8.outReady = 1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.outValid, bus.resultOut, bus.resultHiOut, bus.resultHiValidOut,
           bus.resultWriteOut, bus.killOut, bus.flagsOut, bus.busyOut}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.inReady, 1'b1);
    @(posedge clk); #1;

    // ADD overflow to zero, then carry chains
    issue(4'd1, '1, 64'd1, 64'd0, 0, w);
    check("single_cycle_latency", bus.outValid, 1'b1);
    issue(4'd2, 64'd5, 64'd7, 64'd0, 0, w);
    check("back_to_back_accept", w, 0);
    issue(4'd1, '1, 64'd1, 64'd0, 0, w);
    issue(4'd4, 64'd0, 64'd0, 64'd0, 0, w);

    // MUL latency and busy/inReady behaviour
    issue(4'd13, '1, 64'd2, 64'd0, 0, w);
    lat = 0; busy_ok = 1;
    while (!bus.outValid && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (!bus.outValid && (!bus.busyOut || bus.inReady)) busy_ok = 0;
    end
    check("mul_latency", lat, W + 1);
    check("mul_busy_hold", busy_ok, 1'b1);
    issue(4'd14, -64'sd3, {$urandom, $urandom}, 64'd4, 1, w);

    // backpressure: first op held, second blocked
    wait_idle();
    force_ready = 0;
    issue(4'd6, rval(), rval(), 64'd0, 0, w);
    bus.aluOpIn = 4'd8; bus.operand1In = 64'h1234; bus.operand2In = 64'hFF00; bus.inValid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_ready_valid", {bus.inReady, bus.outValid}, 2'b01);
    end
    @(posedge clk); #1;
    force_ready = 1;
    issue(4'd8, 64'h1234, 64'hFF00, 64'd0, 0, w);
    issue(4'd7, rval(), rval(), 64'd0, 0, w2);
    check("release_throughput", w2, 0);

    // CMP and KILL
    issue(4'd5, 64'd3, 64'd3, 64'd0, 0, w);
    issue(4'd15, rval(), rval(), 64'd0, 0, w);

    // flush in the middle of a multiply
    wait_idle();
    saved = m_flags;
    issue(4'd13, rval(), rval(), 64'd0, 0, w);
    repeat (19) @(posedge clk);
    #1 bus.flushIn = 1'b1;
    @(posedge clk); #1;
    bus.flushIn = 1'b0;
    q.delete();
    m_flags = saved;
    check("flush_state", {bus.busyOut, bus.outValid, bus.flagsOut}, {2'b00, saved});
    issue(4'd2, rval(), rval(), 64'd0, 0, w);
    wait_idle();

    // randomized phase
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(4) == 0) begin @(posedge clk); #1; end
      issue(4'($urandom_range(15)), rval(), rval(), rval(), bit'($urandom_range(1)), w);
    end
    rnd_ready = 0;
    force_ready = 1;
    @(posedge clk); #3;
    wait_idle();
    check("scoreboard_empty", q.size(), 0);

    // WIDTH=8, MUL_STEP=2 instance
    run8(4'd13, 8'hFF, 8'hFF, lat);
    check("mul8_latency", lat, 5);
    check("mul8_ff_ff", {bus8.resultHiOut, bus8.resultOut, bus8.resultHiValidOut, bus8.flagsOut},
          {16'hFE01, 1'b1, 4'b1001});
    for (int i = 0; i < 12; i++) begin
      op8 = ($urandom_range(1) != 0) ? 4'd14 : 4'd13;
      a8 = 8'($urandom); b8 = 8'($urandom);
      up8 = 16'(a8) * 16'(b8);
      sp8 = 16'($signed(a8)) * 16'($signed(b8));
      if (op8 == 4'd14) begin
        up8 = sp8;
        ov8 = (sp8 < -16'sd128) || (sp8 > 16'sd127);
      end else begin
        ov8 = (up8 > 16'd255);
      end
      @(posedge clk); #1;
      run8(op8, a8, b8, lat);
      check($sformatf("mul8 op=%0d a=%0h b=%0h", op8, a8, b8),
            {lat[7:0], bus8.resultHiOut, bus8.resultOut, bus8.flagsOut},
            {8'd5, up8, ov8, up8[7:0] == 8'd0, up8[7], ov8});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
